// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, one stop bit, no parity.
// All outputs come straight from flops so the serial line never glitches.
module uart_tx #(
  parameter int BAUD_RATE = 9600,
  parameter int CLK_FREQ  = 100_000_000,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 tx_en,
  input  logic                 tx_rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     baud_cnt_reg, baud_cnt_next;
  logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 serial_next, busy_next, done_next;
  logic                 bit_end;

  assign bit_end = (baud_cnt_reg == BAUD_LAST);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_serial    <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      tx_serial    <= serial_next;
      tx_busy      <= busy_next;
      tx_done      <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    if (tx_rst) begin
      state_next    = IDLE;
      baud_cnt_next = '0;
      bit_idx_next  = '0;
      shift_next    = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          if (tx_en && tx_start) begin
            shift_next = tx_data;
            state_next = START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt_next = '0;
            bit_idx_next  = '0;
            state_next    = DATA;
          end else begin
            baud_cnt_next = baud_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt_next = '0;
            shift_next    = shift_reg >> 1;
            if (bit_idx_reg == BIT_LAST) begin
              state_next = STOP;
            end else begin
              bit_idx_next = bit_idx_reg + 1'b1;
            end
          end else begin
            baud_cnt_next = baud_cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt_next = '0;
            state_next    = IDLE;
          end else begin
            baud_cnt_next = baud_cnt_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next-state values so the registered copies
  // line up exactly with the state they describe.
  always_comb begin
    serial_next = 1'b1;
    busy_next   = (state_next != IDLE);
    done_next   = (state_next == STOP) && (baud_cnt_next == BAUD_LAST);
    case (state_next)
      START:   serial_next = 1'b0;
      DATA:    serial_next = shift_next[0];
      default: serial_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised scoreboard bench for uart_tx: stimulus queues expected frames, a line
// monitor decodes tx_serial independently and compares data, timing and handshake.
module tb_uart_tx;

  localparam int CLK_FREQ  = 1000;
  localparam int BAUD_RATE = 100;
  localparam int DATA_BITS = 8;
  localparam int B         = CLK_FREQ / BAUD_RATE;
  localparam int FRAME     = (DATA_BITS + 2) * B;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       tx_en = 1'b0;
  logic       tx_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_serial, tx_busy, tx_done;

  always #5 clk = ~clk;

  uart_tx #(.BAUD_RATE(BAUD_RATE), .CLK_FREQ(CLK_FREQ), .DATA_BITS(DATA_BITS)) dut (
    .clk(clk), .arst(arst), .tx_en(tx_en), .tx_rst(tx_rst), .tx_start(tx_start),
    .tx_data(tx_data), .tx_serial(tx_serial), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  typedef struct {
    logic [7:0] data;
    int         t_acc;
  } frame_t;

  frame_t     exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         idle_bad = 0;
  int         free_at = 0;
  int         last_t = 0;
  bit         mon_reset = 1'b0;
  logic [7:0] sdat [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Line monitor: reconstructs each frame from tx_serial alone.
  initial begin : monitor
    bit         in_frame;
    bit         wave_ok;
    bit         stop_ok;
    int         f_start;
    int         off, k, ph;
    logic [7:0] f_data;
    logic       cur_bit;
    frame_t     e;
    in_frame = 1'b0;
    forever begin
      @(negedge clk);
      if (arst || mon_reset) begin
        in_frame  = 1'b0;
        mon_reset = 1'b0;
      end else if (!in_frame) begin
        if (tx_serial === 1'b0) begin
          in_frame = 1'b1;
          f_start  = cyc;
          wave_ok  = (tx_busy === 1'b1);
          stop_ok  = 1'b0;
          f_data   = '0;
          cur_bit  = 1'b0;
          chk("start_time", cyc, (exp_q.size() > 0) ? exp_q[0].t_acc : -1);
        end else if (tx_busy !== 1'b0 || tx_done !== 1'b0) begin
          idle_bad++;
        end
      end else begin
        off = cyc - f_start;
        k   = off / B;
        ph  = off % B;
        if (ph == 0) cur_bit = tx_serial;
        else if (tx_serial !== cur_bit) wave_ok = 1'b0;
        if (tx_busy !== 1'b1) wave_ok = 1'b0;
        if (ph == B / 2) begin
          if (k >= 1 && k <= DATA_BITS) f_data[k-1] = tx_serial;
          if (k == DATA_BITS + 1) stop_ok = (tx_serial === 1'b1);
        end
        if (tx_done === 1'b1) begin
          in_frame = 1'b0;
          chk("frame_pending", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("frame start=%0d done=%0d data=0x%02h expected=0x%02h", f_start, cyc, f_data, e.data);
            chk("data", int'({stop_ok, f_data}), int'({1'b1, e.data}));
            chk("done_time", cyc, e.t_acc + FRAME - 1);
            chk("waveform", int'(wave_ok), 1);
          end
        end else if (off >= FRAME - 1) begin
          in_frame = 1'b0;
          chk("done_missing_offset", off + 1, FRAME - 1);
        end
      end
    end
  end

  task automatic wait_free();
    @(negedge clk);
    while (cyc + 1 < free_at) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    wait_free();
    tx_en    = 1'b1;
    tx_data  = d;
    tx_start = 1'b1;
    last_t   = cyc + 1;
    exp_q.push_back('{data: d, t_acc: last_t});
    free_at  = last_t + FRAME + 1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    tx_data  = ~d;
  endtask

  // tx_start held high: each frame is accepted on the first idle cycle after the last.
  task automatic stream(input int n);
    wait_free();
    tx_en    = 1'b1;
    tx_start = 1'b1;
    for (int i = 0; i < n; i++) begin
      tx_data = sdat[i];
      last_t  = cyc + 1;
      exp_q.push_back('{data: sdat[i], t_acc: last_t});
      free_at = last_t + FRAME + 1;
      @(negedge clk);
      if (i == n - 1) tx_start = 1'b0;
      tx_data = ~sdat[i];
      while (cyc + 1 < free_at) @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    @(negedge clk);
    while (cyc < free_at) @(negedge clk);
  endtask

  initial begin : stimulus
    tx_en    = 1'b1;
    tx_start = 1'b1;
    tx_data  = 8'hA5;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 5 == 4) begin
        chk("reset_serial", int'(tx_serial), 1);
        chk("reset_busy", int'(tx_busy), 0);
        chk("reset_done", int'(tx_done), 0);
      end
    end
    tx_start = 1'b0;
    arst     = 1'b0;
    free_at  = cyc + 1;
    repeat (5) @(negedge clk);

    send(8'h55);
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 25)) @(negedge clk);
      send(8'($urandom_range(0, 255)));
    end
    wait_idle();

    sdat[0] = 8'hA3; sdat[1] = 8'h00; sdat[2] = 8'hFF;
    stream(3);
    wait_idle();
    for (int i = 0; i < 5; i++) sdat[i] = 8'($urandom_range(0, 255));
    stream(5);
    wait_idle();

    @(negedge clk);
    tx_en    = 1'b0;
    tx_start = 1'b1;
    tx_data  = 8'h99;
    repeat (40) @(negedge clk);
    chk("disabled_busy", int'(tx_busy), 0);
    chk("disabled_serial", int'(tx_serial), 1);
    tx_start = 1'b0;
    free_at  = cyc + 1;

    send(8'h0F);
    repeat (30) @(negedge clk);
    tx_data  = 8'hF0;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle();
    repeat (FRAME + 50) @(negedge clk);

    send(8'hA5);
    while (cyc < last_t + 4 * B + 2) @(negedge clk);
    tx_rst = 1'b1;
    @(posedge clk);
    #1;
    tx_rst = 1'b0;
    chk("softrst_serial", int'(tx_serial), 1);
    chk("softrst_busy", int'(tx_busy), 0);
    mon_reset = 1'b1;
    exp_q.delete();
    free_at = cyc + 1;
    repeat (FRAME + 20) @(negedge clk);
    tx_rst   = 1'b1;
    tx_start = 1'b1;
    tx_en    = 1'b1;
    @(posedge clk);
    #1;
    tx_rst   = 1'b0;
    tx_start = 1'b0;
    chk("softrst_priority_busy", int'(tx_busy), 0);
    chk("softrst_priority_serial", int'(tx_serial), 1);
    free_at = cyc + 1;
    send(8'h5A);
    wait_idle();

    send(8'h96);
    while (cyc < last_t + 3 * B + 4) @(negedge clk);
    @(posedge clk);
    #2;
    arst = 1'b1;
    #1;
    chk("arst_serial", int'(tx_serial), 1);
    chk("arst_busy", int'(tx_busy), 0);
    chk("arst_done", int'(tx_done), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    arst    = 1'b0;
    free_at = cyc + 1;
    repeat (FRAME + 20) @(negedge clk);

    send(8'hC3);
    @(negedge clk);
    tx_en = 1'b0;
    wait_idle();
    tx_start = 1'b1;
    tx_data  = 8'h11;
    repeat (30) @(negedge clk);
    chk("en_low_busy", int'(tx_busy), 0);
    send(8'h3C);
    wait_idle();

    repeat (20) @(negedge clk);
    chk("frames_left", exp_q.size(), 0);
    chk("idle_violations", idle_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
